mem_2p_init: RTL and testbench

Parametrised simple dual-port synchronous RAM with one write port and one read port, byte-enable writes, configurable read latency, a read-valid strobe and out-of-range detection. After reset, an internal init state machine clears every location before the ports are accepted, so contents are always defined. It sits where the single-port memory sat: as local storage behind a controller or agent-driven bench. It adds concurrent read/write, a pipelined read path and defined power-up contents.

---
 rtl/mem_2p_init.sv | 130 +++++++++++++
 tb/tb_mem_2p_init.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_2p_init.sv
// Simple dual-port RAM: byte-enable writes, zero-fill after reset, 1- or 2-cycle registered reads.
// Define MEM_BYPASS_EN for write-first same-address collisions; the default build is read-first.
module mem_2p_init #(
   parameter  int DATA_WIDTH   = 32,
   parameter  int DEPTH        = 16,
   parameter  int READ_LATENCY = 1,
   localparam int ADDR_WIDTH   = $clog2(DEPTH),
   localparam int BE_WIDTH     = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [BE_WIDTH-1:0]   wr_be,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_err,
   output logic                  init_done
);

   typedef enum logic {ST_INIT, ST_READY} state_e;

   localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                  clr_en;
   logic                  ready;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  rd_oor;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [READ_LATENCY:0]                 vld_pipe;
   logic [READ_LATENCY:0]                 err_pipe;
   logic [READ_LATENCY:0][DATA_WIDTH-1:0] dat_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      clr_en  = 1'b0;
      case (state_q)
         ST_INIT: begin
            clr_en = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            if (ptr_q == LAST_PTR) begin
               state_d = ST_READY;
               ptr_d   = '0;
            end
         end
         ST_READY: state_d = ST_READY;
         default:  state_d = ST_INIT;
      endcase
   end

   assign ready     = (state_q == ST_READY);
   assign init_done = ready;
   assign wr_acc    = ready && wr_en && ({1'b0, wr_addr} < DEPTH_W);
   assign rd_acc    = ready && rd_en;
   assign rd_oor    = !({1'b0, rd_addr} < DEPTH_W);

   // Storage has no reset; the INIT sweep is what defines its contents.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem_q[ptr_q] <= '0;
      end else if (wr_acc) begin
         for (int b = 0; b < BE_WIDTH; b++)
            if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

   // The array is sampled alongside the request, so an unbypassed collision sees pre-write data.
`ifdef MEM_BYPASS_EN
   logic collide;
   assign collide = wr_acc && (wr_addr == rd_addr);

   always_comb begin
      rd_word = '0;
      if (!rd_oor) begin
         rd_word = mem_q[rd_addr];
         if (collide)
            for (int b = 0; b < BE_WIDTH; b++)
               if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
      end
   end
`else
   always_comb begin
      rd_word = '0;
      if (!rd_oor) rd_word = mem_q[rd_addr];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         err_pipe <= '0;
         dat_pipe <= '0;
      end else begin
         vld_pipe[0] <= rd_acc;
         err_pipe[0] <= rd_acc && rd_oor;
         if (rd_acc) dat_pipe[0] <= rd_word;
         for (int i = 1; i <= READ_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            err_pipe[i] <= err_pipe[i-1];
            if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
         end
      end
   end

   assign rd_valid = vld_pipe[READ_LATENCY];
   assign rd_err   = err_pipe[READ_LATENCY];
   assign rd_data  = dat_pipe[READ_LATENCY];

endmodule

// File: tb/tb_mem_2p_init.sv
// Directed bench: u16 (DEPTH 16, latency 2) and u12 (DEPTH 12, latency 1) share one stimulus stream.
module tb_mem_2p_init;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [3:0]  wr_be   = '0;
   logic [31:0] wr_data = '0;
   logic        rd_en   = 1'b0;
   logic [3:0]  rd_addr = '0;

   logic [31:0] d16, d12;
   logic        v16, v12, e16, e12, i16, i12;

   int n_cmp = 0;
   int n_bad = 0;

   mem_2p_init #(.DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(2)) u16 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d16),
      .rd_valid(v16), .rd_err(e16), .init_done(i16));

   mem_2p_init #(.DATA_WIDTH(32), .DEPTH(12), .READ_LATENCY(1)) u12 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d12),
      .rd_valid(v12), .rd_err(e12), .init_done(i12));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; rd_en = 1'b1; rd_addr = 4'd0;
      wr_en = 1'b1; wr_addr = 4'd2; wr_be = 4'hF; wr_data = 32'hFFFF_FFFF;
      repeat (2) tick;
      n_cmp++; if ({i16, v16, e16, d16} !== 35'h0) begin n_bad++; $display("FAIL reset16: got %h want 0", {i16, v16, e16, d16}); end
      n_cmp++; if ({i12, v12, e12, d12} !== 35'h0) begin n_bad++; $display("FAIL reset12: got %h want 0", {i12, v12, e12, d12}); end
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         rd_en = (k < 12); wr_en = (k < 12); rd_addr = 4'(k);
         tick;
         n_cmp++; if (i16 !== (k == 15) || v16 !== 1'b0) begin n_bad++; $display("FAIL init16 k=%0d: got done=%b vld=%b want done=%b vld=0", k, i16, v16, k == 15); end
         n_cmp++; if (i12 !== (k >= 11) || v12 !== 1'b0) begin n_bad++; $display("FAIL init12 k=%0d: got done=%b vld=%b want done=%b vld=0", k, i12, v12, k >= 11); end
      end
      wr_en = 1'b0;
      // Stream 0..15: u12 answers one cycle later (12..15 out of range), u16 two cycles later.
      for (int c = 0; c < 18; c++) begin
         rd_en = (c < 16); rd_addr = 4'(c);
         tick;
         if (c >= 1 && c <= 16) begin
            n_cmp++; if ({v12, e12, d12} !== {1'b1, (c - 1) >= 12, 32'h0}) begin n_bad++; $display("FAIL clear12 c=%0d: got %h want %h", c, {v12, e12, d12}, {1'b1, (c - 1) >= 12, 32'h0}); end
         end else begin
            n_cmp++; if ({v12, e12} !== 2'b00) begin n_bad++; $display("FAIL clear12 c=%0d: got vld/err %b want 00", c, {v12, e12}); end
         end
         if (c >= 2) begin
            n_cmp++; if ({v16, e16, d16} !== {2'b10, 32'h0}) begin n_bad++; $display("FAIL clear16 c=%0d: got %h want %h", c, {v16, e16, d16}, {2'b10, 32'h0}); end
         end else begin
            n_cmp++; if ({v16, e16} !== 2'b00) begin n_bad++; $display("FAIL clear16 c=%0d: got vld/err %b want 00", c, {v16, e16}); end
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_byte_en;
      logic [33:0] x12 [5];
      logic [33:0] x16 [5];
      x12 = '{{2'b00, 32'h0}, {2'b10, 32'h0}, {2'b10, 32'hAA22CC44}, {2'b00, 32'hAA22CC44}, {2'b00, 32'hAA22CC44}};
      x16 = '{{2'b00, 32'h0}, {2'b00, 32'h0}, {2'b10, 32'h0}, {2'b10, 32'hAA22CC44}, {2'b00, 32'hAA22CC44}};
      wr_en = 1'b1; wr_addr = 4'd3; wr_be = 4'hF; wr_data = 32'hAABB_CCDD; tick;
      wr_be = 4'b0101; wr_data = 32'h1122_3344; tick;
      wr_addr = 4'd7; wr_be = 4'h0; wr_data = 32'hFFFF_FFFF; tick;
      wr_en = 1'b0;
      for (int c = 0; c < 5; c++) begin
         rd_en = (c < 2); rd_addr = (c == 0) ? 4'd7 : 4'd3;
         tick;
         n_cmp++; if ({v12, e12, d12} !== x12[c]) begin n_bad++; $display("FAIL byte_en12 c=%0d: got %h want %h", c, {v12, e12, d12}, x12[c]); end
         n_cmp++; if ({v16, e16, d16} !== x16[c]) begin n_bad++; $display("FAIL byte_en16 c=%0d: got %h want %h", c, {v16, e16, d16}, x16[c]); end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_collision;
      logic [31:0] first;
      logic [33:0] x12 [5];
      logic [33:0] x16 [5];
`ifdef MEM_BYPASS_EN
      first = 32'hDEAD_BEEF;
`else
      first = 32'h0;
`endif
      x12 = '{{2'b00, 32'hAA22CC44}, {2'b10, first}, {2'b10, 32'hDEADBEEF}, {2'b00, 32'hDEADBEEF}, {2'b00, 32'hDEADBEEF}};
      x16 = '{{2'b00, 32'hAA22CC44}, {2'b00, 32'hAA22CC44}, {2'b10, first}, {2'b10, 32'hDEADBEEF}, {2'b00, 32'hDEADBEEF}};
      for (int c = 0; c < 5; c++) begin
         wr_en = (c == 0); wr_addr = 4'd5; wr_be = 4'hF; wr_data = 32'hDEAD_BEEF;
         rd_en = (c < 2); rd_addr = 4'd5;
         tick;
         n_cmp++; if ({v12, e12, d12} !== x12[c]) begin n_bad++; $display("FAIL collide12 c=%0d: got %h want %h", c, {v12, e12, d12}, x12[c]); end
         n_cmp++; if ({v16, e16, d16} !== x16[c]) begin n_bad++; $display("FAIL collide16 c=%0d: got %h want %h", c, {v16, e16, d16}, x16[c]); end
      end
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic test_out_of_range;
      logic [33:0] x12 [6];
      logic [33:0] x16 [6];
      x12 = '{{2'b00, 32'hDEADBEEF}, {2'b00, 32'hDEADBEEF}, {2'b11, 32'h0}, {2'b10, 32'h0}, {2'b00, 32'h0}, {2'b00, 32'h0}};
      x16 = '{{2'b00, 32'hDEADBEEF}, {2'b00, 32'hDEADBEEF}, {2'b00, 32'hDEADBEEF}, {2'b10, 32'h55}, {2'b10, 32'h0}, {2'b00, 32'h0}};
      for (int c = 0; c < 6; c++) begin
         wr_en = (c == 0); wr_addr = 4'd13; wr_be = 4'hF; wr_data = 32'h55;
         rd_en = (c == 1 || c == 2); rd_addr = (c == 1) ? 4'd13 : 4'd1;
         tick;
         n_cmp++; if ({v12, e12, d12} !== x12[c]) begin n_bad++; $display("FAIL oor12 c=%0d: got %h want %h", c, {v12, e12, d12}, x12[c]); end
         n_cmp++; if ({v16, e16, d16} !== x16[c]) begin n_bad++; $display("FAIL oor16 c=%0d: got %h want %h", c, {v16, e16, d16}, x16[c]); end
      end
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [33:0] exp;
      for (int a = 0; a < 8; a++) begin
         wr_en = 1'b1; wr_addr = 4'(a); wr_be = 4'hF; wr_data = 32'hC0DE_5A00 | a;
         tick;
      end
      wr_en = 1'b0;
      for (int c = 0; c < 10; c++) begin
         rd_en = (c < 8); rd_addr = 4'(c);
         tick;
         if (c == 0)      exp = {2'b00, 32'h0};
         else if (c == 9) exp = {2'b00, 32'hC0DE_5A07};
         else             exp = {2'b10, 32'hC0DE_5A00 | (c - 1)};
         n_cmp++; if ({v12, e12, d12} !== exp) begin n_bad++; $display("FAIL stream12 c=%0d: got %h want %h", c, {v12, e12, d12}, exp); end
         exp = (c < 2) ? {2'b00, 32'h0} : {2'b10, 32'hC0DE_5A00 | (c - 2)};
         n_cmp++; if ({v16, e16, d16} !== exp) begin n_bad++; $display("FAIL stream16 c=%0d: got %h want %h", c, {v16, e16, d16}, exp); end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [33:0] x12 [4];
      logic [33:0] x16 [4];
      // Read in flight when reset hits.
      rd_en = 1'b1; rd_addr = 4'd2; tick;
      rd_en = 1'b0; rst_n = 1'b0; #1;
      n_cmp++; if ({i16, v16, e16, d16} !== 35'h0) begin n_bad++; $display("FAIL rst_rd16: got %h want 0", {i16, v16, e16, d16}); end
      n_cmp++; if ({i12, v12, e12, d12} !== 35'h0) begin n_bad++; $display("FAIL rst_rd12: got %h want 0", {i12, v12, e12, d12}); end
      repeat (2) tick;
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick;
         n_cmp++; if ({i16, v16} !== {k == 15, 1'b0}) begin n_bad++; $display("FAIL rel1_16 k=%0d: got done/vld %b want %b", k, {i16, v16}, {k == 15, 1'b0}); end
         n_cmp++; if ({i12, v12} !== {k >= 11, 1'b0}) begin n_bad++; $display("FAIL rel1_12 k=%0d: got done/vld %b want %b", k, {i12, v12}, {k >= 11, 1'b0}); end
      end
      // Reset again, then cut INIT short after five clear cycles.
      rst_n = 1'b0; tick; rst_n = 1'b1;
      repeat (5) tick;
      rst_n = 1'b0; #1;
      n_cmp++; if ({i16, v16, i12, v12} !== 4'b0000) begin n_bad++; $display("FAIL rst_init: got %b want 0000", {i16, v16, i12, v12}); end
      tick; rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick;
         n_cmp++; if ({i16, v16} !== {k == 15, 1'b0}) begin n_bad++; $display("FAIL rel2_16 k=%0d: got done/vld %b want %b", k, {i16, v16}, {k == 15, 1'b0}); end
         n_cmp++; if ({i12, v12} !== {k >= 11, 1'b0}) begin n_bad++; $display("FAIL rel2_12 k=%0d: got done/vld %b want %b", k, {i12, v12}, {k >= 11, 1'b0}); end
      end
      // Contents cleared again; a write is visible to the next cycle's read.
      x12 = '{{2'b00, 32'h0}, {2'b10, 32'h0}, {2'b10, 32'h12345678}, {2'b00, 32'h12345678}};
      x16 = '{{2'b00, 32'h0}, {2'b00, 32'h0}, {2'b10, 32'h0}, {2'b10, 32'h12345678}};
      for (int c = 0; c < 4; c++) begin
         wr_en = (c == 0); wr_addr = 4'd9; wr_be = 4'hF; wr_data = 32'h1234_5678;
         rd_en = (c < 2); rd_addr = (c == 0) ? 4'd3 : 4'd9;
         tick;
         n_cmp++; if ({v12, e12, d12} !== x12[c]) begin n_bad++; $display("FAIL post12 c=%0d: got %h want %h", c, {v12, e12, d12}, x12[c]); end
         n_cmp++; if ({v16, e16, d16} !== x16[c]) begin n_bad++; $display("FAIL post16 c=%0d: got %h want %h", c, {v16, e16, d16}, x16[c]); end
      end
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   initial begin
      test_reset;
      test_byte_en;
      test_collision;
      test_out_of_range;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
